// File: rtl/vm_stock_charger.sv
// vm_stock_charger: per-product stock keeper for the vending machine.
// Serves one charge (restock) or vend (withdraw) request at a time through a
// valid/ready handshake and answers every request with exactly one response
// pulse carrying the resulting count and an error code.
// Note: the product-type input is called prod_type because "type" is a
// reserved word in SystemVerilog.
module vm_stock_charger #(
  parameter int NUM_TYPES  = 4,
  parameter int TYPE_W     = 2,
  parameter int COUNT_W    = 5,
  parameter int MAX_STOCK  = 20,
  parameter int INIT_STOCK = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 mode,
  input  logic [TYPE_W-1:0]    prod_type,
  input  logic [COUNT_W-1:0]   number,
  output logic                 resp_valid,
  output logic [1:0]           resp_err,
  output logic [COUNT_W-1:0]   resp_count,
  output logic [NUM_TYPES-1:0] empty_flags,
  output logic [NUM_TYPES-1:0] full_flags
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_BAD_TYPE  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

  localparam logic [TYPE_W:0]    NUM_TYPES_W = (TYPE_W+1)'(NUM_TYPES);
  localparam logic [COUNT_W:0]   MAX_WIDE    = (COUNT_W+1)'(MAX_STOCK);
  localparam logic [COUNT_W-1:0] MAX_COUNT   = COUNT_W'(MAX_STOCK);
  localparam logic [COUNT_W-1:0] INIT_COUNT  = COUNT_W'(INIT_STOCK);
  localparam logic               INIT_EMPTY  = (INIT_STOCK == 0);
  localparam logic               INIT_FULL   = (INIT_STOCK == MAX_STOCK);

  state_t             state;
  logic               mode_q;
  logic [TYPE_W-1:0]  type_q;
  logic [COUNT_W-1:0] number_q;
  logic [COUNT_W-1:0] stock [NUM_TYPES];
  logic [1:0]         res_err;
  logic [COUNT_W-1:0] res_count;

  logic               bad_type;
  logic [COUNT_W-1:0] cur;
  logic [COUNT_W:0]   sum;
  logic [COUNT_W-1:0] diff;
  logic [1:0]         chk_err;
  logic [COUNT_W-1:0] chk_count;

  // Evaluate the latched request against the addressed stock (one-hot select avoids out-of-range indexing)
  always_comb begin
    bad_type = ({1'b0, type_q} >= NUM_TYPES_W);
    cur      = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (!bad_type && (type_q == TYPE_W'(i))) begin
        cur = stock[i];
      end
    end
    sum       = {1'b0, cur} + {1'b0, number_q};
    diff      = cur - number_q;
    chk_err   = ERR_OK;
    chk_count = cur;
    if (bad_type) begin
      chk_err   = ERR_BAD_TYPE;
      chk_count = '0;
    end else if (mode_q) begin
      if (sum > MAX_WIDE) begin
        chk_err = ERR_OVERFLOW;
      end else begin
        chk_count = sum[COUNT_W-1:0];
      end
    end else begin
      if (number_q > cur) begin
        chk_err = ERR_UNDERFLOW;
      end else begin
        chk_count = diff;
      end
    end
  end

  // Request FSM: accept, evaluate, then commit the stock write and pulse the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      mode_q      <= 1'b0;
      type_q      <= '0;
      number_q    <= '0;
      res_err     <= ERR_OK;
      res_count   <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= ERR_OK;
      resp_count  <= '0;
      empty_flags <= {NUM_TYPES{INIT_EMPTY}};
      full_flags  <= {NUM_TYPES{INIT_FULL}};
      for (int i = 0; i < NUM_TYPES; i++) begin
        stock[i] <= INIT_COUNT;
      end
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            mode_q    <= mode;
            type_q    <= prod_type;
            number_q  <= number;
            req_ready <= 1'b0;
            state     <= CHECK;
          end else begin
            req_ready <= 1'b1;
          end
        end
        CHECK: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b0;
          res_err    <= chk_err;
          res_count  <= chk_count;
          state      <= COMMIT;
        end
        COMMIT: begin
          if (res_err == ERR_OK) begin
            for (int i = 0; i < NUM_TYPES; i++) begin
              if (type_q == TYPE_W'(i)) begin
                stock[i]       <= res_count;
                empty_flags[i] <= (res_count == '0);
                full_flags[i]  <= (res_count == MAX_COUNT);
              end
            end
          end
          resp_valid <= 1'b1;
          resp_err   <= res_err;
          resp_count <= res_count;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_stock_charger.sv
// Testbench for vm_stock_charger: directed requests checked against a
// behavioural stock model every cycle, plus hand-computed literal checks.
module tb_vm_stock_charger;

  localparam int NT = 3;
  localparam int TW = 2;
  localparam int CW = 5;
  localparam int MX = 20;
  localparam int IS = 0;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          mode;
  logic [TW-1:0] prod_type;
  logic [CW-1:0] number;
  logic          resp_valid;
  logic [1:0]    resp_err;
  logic [CW-1:0] resp_count;
  logic [NT-1:0] empty_flags;
  logic [NT-1:0] full_flags;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  // model state
  int m_stock [NT];
  bit m_ready;
  int m_pend;
  bit m_rv;
  int m_err;
  int m_cnt;
  int m_mode;
  int m_type;
  int m_num;

  // captured response of the last directed request
  int last_err;
  int last_cnt;
  int last_lat;

  vm_stock_charger #(
    .NUM_TYPES (NT),
    .TYPE_W    (TW),
    .COUNT_W   (CW),
    .MAX_STOCK (MX),
    .INIT_STOCK(IS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mode       (mode),
    .prod_type  (prod_type),
    .number     (number),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_count (resp_count),
    .empty_flags(empty_flags),
    .full_flags (full_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Apply one request to the model's stock table using the plain rules
  task automatic model_op();
    if (m_type >= NT) begin
      m_err = 1;
      m_cnt = 0;
    end else if (m_mode != 0) begin
      if (m_stock[m_type] + m_num > MX) begin
        m_err = 2;
        m_cnt = m_stock[m_type];
      end else begin
        m_stock[m_type] = m_stock[m_type] + m_num;
        m_err = 0;
        m_cnt = m_stock[m_type];
      end
    end else begin
      if (m_num > m_stock[m_type]) begin
        m_err = 3;
        m_cnt = m_stock[m_type];
      end else begin
        m_stock[m_type] = m_stock[m_type] - m_num;
        m_err = 0;
        m_cnt = m_stock[m_type];
      end
    end
  endtask

  // Behavioural model: a request accepted while ready is answered two edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) m_stock[i] = IS;
      m_ready = 0;
      m_pend  = 0;
      m_rv    = 0;
    end else begin
      m_rv = 0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          model_op();
          m_rv    = 1;
          m_ready = 1;
        end
      end else if (m_ready && req_valid) begin
        m_mode  = int'(mode);
        m_type  = int'(prod_type);
        m_num   = int'(number);
        m_pend  = 2;
        m_ready = 0;
      end else begin
        m_ready = 1;
      end
    end
  end

  // Cycle compare of every DUT output against the model
  always @(negedge clk) begin
    if (checking) begin
      int exp_empty;
      int exp_full;
      exp_empty = 0;
      exp_full  = 0;
      for (int i = 0; i < NT; i++) begin
        if (m_stock[i] == 0)  exp_empty = exp_empty | (1 << i);
        if (m_stock[i] == MX) exp_full  = exp_full  | (1 << i);
      end
      check_value("cyc_req_ready", int'(req_ready), int'(m_ready));
      check_value("cyc_resp_valid", int'(resp_valid), int'(m_rv));
      check_value("cyc_empty_flags", int'(empty_flags), exp_empty);
      check_value("cyc_full_flags", int'(full_flags), exp_full);
      if (m_rv) begin
        check_value("cyc_resp_err", int'(resp_err), m_err);
        check_value("cyc_resp_count", int'(resp_count), m_cnt);
      end
    end
  end

  // Drive one request from a negedge and capture its response and latency
  task automatic apply_stimulus(input bit md, input int tp, input int nm);
    int waited;
    bit got;
    waited = 0;
    while (!m_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_value("stim_ready_wait", int'(m_ready), 1);
    mode      = md;
    prod_type = TW'(tp);
    number    = CW'(nm);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    mode      = ~mode;
    prod_type = ~prod_type;
    number    = ~number;
    last_lat  = 1;
    got       = 0;
    while (!got && last_lat < 8) begin
      @(negedge clk);
      last_lat++;
      if (resp_valid) got = 1;
    end
    check_value("resp_seen", int'(got), 1);
    check_value("resp_latency", last_lat, 3);
    last_err = int'(resp_err);
    last_cnt = int'(resp_count);
  endtask

  task automatic check_output(input string name, input int exp_err, input int exp_cnt);
    check_value({name, "_err"}, last_err, exp_err);
    check_value({name, "_cnt"}, last_cnt, exp_cnt);
  endtask

  // Back-to-back stimulus table: only entries 0, 3 and 6 land on accept edges
  bit bb_md [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int bb_tp [9] = '{2, 3, 2, 2, 2, 0, 2, 3, 1};
  int bb_nm [9] = '{3, 31, 31, 4, 31, 9, 5, 1, 30};

  // Main directed sequence
  initial begin
    int pulse_j [$];
    int pulse_c [$];
    int rv_seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mode      = 1'b0;
    prod_type = '0;
    number    = '0;
    @(negedge clk);
    checking = 1;
    repeat (2) @(negedge clk);
    check_value("reset_ready_low", int'(req_ready), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_value("reset_ready", int'(req_ready), 1);
    check_value("reset_empty", int'(empty_flags), 7);
    check_value("reset_full", int'(full_flags), 0);
    check_value("reset_resp_valid", int'(resp_valid), 0);
    check_value("reset_resp_err", int'(resp_err), 0);
    check_value("reset_resp_count", int'(resp_count), 0);

    apply_stimulus(1'b1, 0, 15);
    check_output("charge15", 0, 15);
    check_value("charge15_empty0", int'(empty_flags[0]), 0);
    apply_stimulus(1'b1, 0, 6);
    check_output("overflow", 2, 15);
    apply_stimulus(1'b1, 0, 5);
    check_output("fill_max", 0, 20);
    check_value("fill_max_full0", int'(full_flags[0]), 1);
    apply_stimulus(1'b0, 0, 20);
    check_output("vend_all", 0, 0);
    check_value("vend_all_empty0", int'(empty_flags[0]), 1);
    check_value("vend_all_full0", int'(full_flags[0]), 0);
    apply_stimulus(1'b0, 2, 1);
    check_output("underflow", 3, 0);
    apply_stimulus(1'b0, 2, 0);
    check_output("vend_zero", 0, 0);
    apply_stimulus(1'b1, 3, 2);
    check_output("bad_type", 1, 0);
    apply_stimulus(1'b1, 1, 7);
    check_output("charge7", 0, 7);
    apply_stimulus(1'b0, 1, 8);
    check_output("underflow7", 3, 7);
    apply_stimulus(1'b0, 1, 7);
    check_output("vend_exact", 0, 0);

    // back-to-back: req_valid held for nine edges
    while (!m_ready) @(negedge clk);
    mode      = bb_md[0];
    prod_type = TW'(bb_tp[0]);
    number    = CW'(bb_nm[0]);
    req_valid = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (resp_valid) begin
        pulse_j.push_back(j);
        pulse_c.push_back(int'(resp_count) + 100 * int'(resp_err));
      end
      if (j <= 8) begin
        mode      = bb_md[j];
        prod_type = TW'(bb_tp[j]);
        number    = CW'(bb_nm[j]);
      end
      if (j == 9) req_valid = 1'b0;
    end
    check_value("b2b_pulses", pulse_j.size(), 3);
    if (pulse_j.size() == 3) begin
      check_value("b2b_pos0", pulse_j[0], 3);
      check_value("b2b_pos1", pulse_j[1], 6);
      check_value("b2b_pos2", pulse_j[2], 9);
      check_value("b2b_res0", pulse_c[0], 3);
      check_value("b2b_res1", pulse_c[1], 7);
      check_value("b2b_res2", pulse_c[2], 2);
    end

    // reset in the middle of an operation
    apply_stimulus(1'b1, 1, 4);
    check_output("pre_reset", 0, 4);
    mode      = 1'b1;
    prod_type = 2'd1;
    number    = 5'd10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    rv_seen = 0;
    @(negedge clk);
    check_value("midreset_ready_low", int'(req_ready), 0);
    if (resp_valid) rv_seen++;
    @(negedge clk);
    if (resp_valid) rv_seen++;
    #2 rst_n = 1'b1;
    @(negedge clk);
    if (resp_valid) rv_seen++;
    check_value("midreset_ready", int'(req_ready), 1);
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    check_value("midreset_no_resp", rv_seen, 0);
    check_value("midreset_empty", int'(empty_flags), 7);
    apply_stimulus(1'b0, 1, 0);
    check_output("post_reset", 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
